logic_mux_unit: RTL and testbench
=================================

# logic_mux_unit

Registered 4-bit logic/select unit. It computes the bitwise AND and bitwise OR of two operands, and selects one of four data words through a 4:1 multiplexer. All three results are captured in output registers on one clock. It is a leaf datapath block used next to the adder/XOR primitives of the small ALU layer.

## Interface
Parameters:
- WIDTH, default 4: width of operands, mux data inputs and all results.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- in_valid  input  1  qualifies a, b, mux_a0..mux_a3 and mux_sel for capture.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- mux_a0  input  WIDTH  mux data input, selected when mux_sel = 0.
- mux_a1  input  WIDTH  mux data input, selected when mux_sel = 1.
- mux_a2  input  WIDTH  mux data input, selected when mux_sel = 2.
- mux_a3  input  WIDTH  mux data input, selected when mux_sel = 3.
- mux_sel  input  2  mux select.
- and_out  output  WIDTH  registered a & b.
- or_out  output  WIDTH  registered a | b.
- mux_out  output  WIDTH  registered mux_a[mux_sel].
- out_valid  output  1  high for exactly the cycle after each accepted input.

## Operation
- Combinational stage:
  - and_nx = a & b, bit by bit.
  - or_nx = a | b, bit by bit.
  - mux_nx = mux_a0/a1/a2/a3 for mux_sel = 0/1/2/3. The mux has no default-X path; all four codes are decoded.
- Register stage, on each rising clk edge, in priority order:
  - reset = 1: and_out, or_out and mux_out are all 0, and out_valid = 0.
  - else if in_valid = 1: and_out, or_out and mux_out load and_nx, or_nx and mux_nx; out_valid = 1.
  - else: and_out, or_out and mux_out hold their previous values; out_valid = 0.
- There are no carries, no overflow and no width growth. Results are exactly WIDTH bits.
- Inputs are unregistered. They must be stable around the clk edge when in_valid = 1.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N with in_valid = 1 appear on the outputs after edge N, with out_valid high until edge N+1.
- Throughput is one result per cycle. Back-to-back in_valid is supported with no bubbles.
- There is no backpressure; the downstream must accept every out_valid pulse.
- Reset values: and_out = 0, or_out = 0, mux_out = 0, out_valid = 0.
- Reset mid-stream: if reset and in_valid are both high at the same edge, reset wins. The data is dropped and out_valid = 0 on the next cycle.
- The first accepted input after reset deasserts produces out_valid one edge later.
- Changes to mux_sel while in_valid = 0 have no effect on mux_out.

## Structure
- Shared package logic_pkg holds:
  - the WIDTH default (LOGIC_W = 4);
  - mux select encodings SEL_A0..SEL_A3 = 2'd0..2'd3.
- One sub-module is natural: mux4_sel, a purely combinational WIDTH-bit 4:1 mux. It is instantiated once.
- The AND and OR functions are inline expressions.
- Output registers sit in the top level, in a single clocked process.

## Test plan
- Reset: hold reset for 2 cycles with arbitrary inputs and in_valid = 1 -> all outputs 0 and out_valid = 0. Release reset -> outputs remain 0 until the first accepted input.
- Logic vectors, each with in_valid = 1 for one cycle and checked one cycle later:
  - a = 0x0, b = 0x0 -> and_out = 0x0, or_out = 0x0.
  - a = 0x1, b = 0xE -> and_out = 0x0, or_out = 0xF.
  - a = 0xE, b = 0x1 -> and_out = 0x0, or_out = 0xF.
  - a = 0xF, b = 0xF -> and_out = 0xF, or_out = 0xF.
- Mux sweep: mux_a0..mux_a3 = 0xE, 0xA, 0xB, 0x4. Apply mux_sel = 0, 1, 2, 3 on consecutive cycles with in_valid = 1 -> mux_out = 0xE, 0xA, 0xB, 0x4 on consecutive cycles, and out_valid stays high throughout.
- Hold: after loading a = 0xF, b = 0xF, drop in_valid and change a, b and mux_sel -> outputs unchanged and out_valid = 0.
- Reset priority: reset = 1 and in_valid = 1 at the same edge with a = 0xF, b = 0xF -> next cycle all outputs 0 and out_valid = 0.

Source files
------------

// File: rtl/logic_pkg.sv
// Shared constants for the small ALU logic layer: default datapath width
// and the 4:1 mux select encodings.
package logic_pkg;

    localparam int LOGIC_W = 4;

    localparam logic [1:0] SEL_A0 = 2'd0;
    localparam logic [1:0] SEL_A1 = 2'd1;
    localparam logic [1:0] SEL_A2 = 2'd2;
    localparam logic [1:0] SEL_A3 = 2'd3;

endpackage

// File: rtl/logic_mux_unit_mux4_sel.sv
// Purely combinational WIDTH-bit 4:1 multiplexer; every select code is
// decoded explicitly so no X can leak out for a legal select.
module mux4_sel
    import logic_pkg::*;
#(
    parameter int WIDTH = LOGIC_W
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = d0;
        unique case (sel)
            SEL_A0: y = d0;
            SEL_A1: y = d1;
            SEL_A2: y = d2;
            SEL_A3: y = d3;
        endcase
    end

endmodule

// File: rtl/logic_mux_unit.sv
// Registered logic/select unit: a & b, a | b and a 4:1 mux result, all
// captured together with one cycle of latency.
module logic_mux_unit
    import logic_pkg::*;
#(
    parameter int WIDTH = LOGIC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] mux_a0,
    input  logic [WIDTH-1:0] mux_a1,
    input  logic [WIDTH-1:0] mux_a2,
    input  logic [WIDTH-1:0] mux_a3,
    input  logic [1:0]       mux_sel,
    output logic [WIDTH-1:0] and_out,
    output logic [WIDTH-1:0] or_out,
    output logic [WIDTH-1:0] mux_out,
    output logic             out_valid
);

    // Handshake: a transfer happens on every edge where in_valid is high;
    // there is no ready, so out_valid pulses for exactly one cycle per
    // accepted input and the consumer must take it that cycle.

    logic [WIDTH-1:0] and_nx;
    logic [WIDTH-1:0] or_nx;
    logic [WIDTH-1:0] mux_nx;

    assign and_nx = a & b;
    assign or_nx  = a | b;

    mux4_sel #(.WIDTH(WIDTH)) u_mux (
        .d0  (mux_a0),
        .d1  (mux_a1),
        .d2  (mux_a2),
        .d3  (mux_a3),
        .sel (mux_sel),
        .y   (mux_nx)
    );

    // Reset beats a coincident in_valid; without in_valid the results hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            and_out   <= '0;
            or_out    <= '0;
            mux_out   <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            and_out   <= and_nx;
            or_out    <= or_nx;
            mux_out   <= mux_nx;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_mux_unit.sv
// Directed self-checking bench for logic_mux_unit: reset, logic vectors,
// mux sweep, hold behaviour and reset priority.
module tb_logic_mux_unit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] a, b;
    logic [W-1:0] mux_a0, mux_a1, mux_a2, mux_a3;
    logic [1:0]   mux_sel;
    logic [W-1:0] and_out, or_out, mux_out;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;

    logic_mux_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .mux_a0    (mux_a0),
        .mux_a1    (mux_a1),
        .mux_a2    (mux_a2),
        .mux_a3    (mux_a3),
        .mux_sel   (mux_sel),
        .and_out   (and_out),
        .or_out    (or_out),
        .mux_out   (mux_out),
        .out_valid (out_valid)
    );

    // driver: change inputs on the falling edge, away from the sampling edge
    task automatic drive(input logic rst, input logic vld, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input logic [1:0] sel);
        @(negedge clk);
        reset    = rst;
        in_valid = vld;
        a        = aa;
        b        = bb;
        mux_sel  = sel;
    endtask

    task automatic test_reset();
        mux_a0 = 4'h3; mux_a1 = 4'h5; mux_a2 = 4'h9; mux_a3 = 4'hC;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 4'hF, 4'h7, 2'd3);
            @(posedge clk); #1;
            checks++;
            if ({and_out, or_out, mux_out, out_valid} !== 13'h0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: and=%h or=%h mux=%h valid=%b, want 0 0 0 0",
                         i, and_out, or_out, mux_out, out_valid);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 4'hA, 4'h6, 2'd2);
            @(posedge clk); #1;
            checks++;
            if ({and_out, or_out, mux_out, out_valid} !== 13'h0) begin
                errors++;
                $display("FAIL reset_release[%0d]: and=%h or=%h mux=%h valid=%b, want 0 0 0 0",
                         i, and_out, or_out, mux_out, out_valid);
            end
        end
    endtask

    task automatic test_logic();
        logic [W-1:0] va [4]    = '{4'h0, 4'h1, 4'hE, 4'hF};
        logic [W-1:0] vb [4]    = '{4'h0, 4'hE, 4'h1, 4'hF};
        logic [W-1:0] eand [4]  = '{4'h0, 4'h0, 4'h0, 4'hF};
        logic [W-1:0] eor [4]   = '{4'h0, 4'hF, 4'hF, 4'hF};
        logic [1:0]   vsel [4]  = '{2'd1, 2'd0, 2'd3, 2'd2};
        logic [W-1:0] emux [4]  = '{4'h5, 4'h3, 4'hC, 4'h9};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, va[i], vb[i], vsel[i]);
            @(posedge clk); #1;
            checks++;
            if ({and_out, or_out, mux_out, out_valid} !== {eand[i], eor[i], emux[i], 1'b1}) begin
                errors++;
                $display("FAIL logic_vec[%0d]: and=%h or=%h mux=%h valid=%b, want %h %h %h 1",
                         i, and_out, or_out, mux_out, out_valid, eand[i], eor[i], emux[i]);
            end
            drive(1'b0, 1'b0, va[i], vb[i], vsel[i]);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL logic_pulse[%0d]: valid=%b, want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_mux_sweep();
        logic [W-1:0] data [4] = '{4'hE, 4'hA, 4'hB, 4'h4};
        logic [W-1:0] exp;
        mux_a0 = data[0]; mux_a1 = data[1]; mux_a2 = data[2]; mux_a3 = data[3];
        for (int i = 0; i < 4; i++) exp_q.push_back(data[i]);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 4'h6, 4'h3, 2'(i));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            checks++;
            if ({and_out, or_out, mux_out, out_valid} !== {4'h2, 4'h7, exp, 1'b1}) begin
                errors++;
                $display("FAIL mux_sweep[%0d]: and=%h or=%h mux=%h valid=%b, want 2 7 %h 1",
                         i, and_out, or_out, mux_out, out_valid, exp);
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, 4'hF, 4'hF, 2'd0);
        @(posedge clk); #1;
        checks++;
        if ({and_out, or_out, mux_out, out_valid} !== {4'hF, 4'hF, 4'hE, 1'b1}) begin
            errors++;
            $display("FAIL hold_load: and=%h or=%h mux=%h valid=%b, want f f e 1",
                     and_out, or_out, mux_out, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 4'(i), 4'(i + 2), 2'(i + 1));
            @(posedge clk); #1;
            checks++;
            if ({and_out, or_out, mux_out, out_valid} !== {4'hF, 4'hF, 4'hE, 1'b0}) begin
                errors++;
                $display("FAIL hold[%0d]: and=%h or=%h mux=%h valid=%b, want f f e 0",
                         i, and_out, or_out, mux_out, out_valid);
            end
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 1'b1, 4'hF, 4'hF, 2'd1);
        @(posedge clk); #1;
        checks++;
        if ({and_out, or_out, mux_out, out_valid} !== 13'h0) begin
            errors++;
            $display("FAIL reset_priority: and=%h or=%h mux=%h valid=%b, want 0 0 0 0",
                     and_out, or_out, mux_out, out_valid);
        end
        drive(1'b0, 1'b0, 4'hF, 4'hF, 2'd1);
        @(posedge clk); #1;
        checks++;
        if ({and_out, or_out, mux_out, out_valid} !== 13'h0) begin
            errors++;
            $display("FAIL post_reset_idle: and=%h or=%h mux=%h valid=%b, want 0 0 0 0",
                     and_out, or_out, mux_out, out_valid);
        end
        drive(1'b0, 1'b1, 4'hC, 4'h5, 2'd3);
        @(posedge clk); #1;
        checks++;
        if ({and_out, or_out, mux_out, out_valid} !== {4'h4, 4'hD, 4'h4, 1'b1}) begin
            errors++;
            $display("FAIL first_after_reset: and=%h or=%h mux=%h valid=%b, want 4 d 4 1",
                     and_out, or_out, mux_out, out_valid);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; mux_sel = '0;
        mux_a0 = '0; mux_a1 = '0; mux_a2 = '0; mux_a3 = '0;
        test_reset();
        test_logic();
        test_mux_sweep();
        test_hold();
        test_reset_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
